// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a two-entry skid buffer.
// ex_ready_o is registered, so MEM backpressure never reaches EX combinationally.
module ex_mem_skid #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic [ADDR_W-1:0] ex_waddr_i,
   input  logic              ex_we_i,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic              flush_i,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [ADDR_W-1:0] mem_waddr_o,
   output logic              mem_we_o,
   output logic              mem_valid_o,
   input  logic              mem_ready_i,
   output logic [1:0]        count_o
);

   typedef struct packed {
      logic [DATA_W-1:0] wdata;
      logic [ADDR_W-1:0] waddr;
      logic              we;
   } ent_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state, state_n;
   ent_t   main_q, main_n;
   ent_t   skid_q, skid_n;
   ent_t   in_ent;
   logic   rdy_q, rdy_n;
   logic   accept, deliver;

   assign in_ent  = {ex_wdata_i, ex_waddr_i, ex_we_i};
   assign accept  = ex_valid_i & rdy_q;
   assign deliver = mem_valid_o & mem_ready_i;

   // Reset clears everything and holds ready low until the first live edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
         rdy_q  <= 1'b0;
      end else begin
         state  <= state_n;
         main_q <= main_n;
         skid_q <= skid_n;
         rdy_q  <= rdy_n;
      end
   end

   always_comb begin
      state_n = state;
      main_n  = main_q;
      skid_n  = skid_q;
      if (flush_i) begin
         state_n = EMPTY;
         main_n  = '0;
         skid_n  = '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  main_n  = in_ent;
                  state_n = BUSY;
               end
            end
            BUSY: begin
               if (accept && !deliver) begin
                  skid_n  = in_ent;
                  state_n = FULL;
               end else if (accept && deliver) begin
                  main_n  = in_ent;
               end else if (deliver) begin
                  state_n = EMPTY;
               end
            end
            FULL: begin
               if (deliver) begin
                  main_n  = skid_q;
                  state_n = BUSY;
               end
            end
            default: begin
               state_n = EMPTY;
            end
         endcase
      end
      rdy_n = (state_n != FULL);
   end

   always_comb begin
      ex_ready_o  = rdy_q;
      mem_valid_o = (state != EMPTY);
      mem_wdata_o = main_q.wdata;
      mem_waddr_o = main_q.waddr;
      mem_we_o    = main_q.we & mem_valid_o;
      count_o     = state;
   end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
Registered EX->MEM boundary of the pipeline. It captures the ALU result triple (write data, write address, write enable) produced by the execute stage and presents it to the memory stage. A valid/ready handshake with a 2-entry skid buffer sustains 1 transfer/cycle without a combinational ready path from MEM back into EX. A flush input discards in-flight results.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register write address

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset (rst==0 resets on clk edge)
ex_wdata_i  input  DATA_W  result from execute stage
ex_waddr_i  input  ADDR_W  destination register from execute stage
ex_we_i  input  1  register write enable from execute stage
ex_valid_i  input  1  execute stage presents a result this cycle
ex_ready_o  output  1  block can accept a result this cycle (registered)
flush_i  input  1  discard all buffered results
mem_wdata_o  output  DATA_W  head result data to memory stage
mem_waddr_o  output  ADDR_W  head result address
mem_we_o  output  1  head write enable, gated by mem_valid_o
mem_valid_o  output  1  head entry valid
mem_ready_i  input  1  memory stage consumes head this cycle
count_o  output  2  entries held (0..2)

Behaviour:
- Storage: main register (drives mem_* outputs) and skid register, each holding {wdata, waddr, we}.
- accept = ex_valid_i & ex_ready_o; deliver = mem_valid_o & mem_ready_i.
- States: EMPTY (count 0), BUSY (main valid), FULL (main + skid valid).
- EMPTY: accept -> load main, go BUSY.
- BUSY:
  - accept & !deliver -> load skid, go FULL.
  - accept & deliver -> load main with new entry, stay BUSY.
  - !accept & deliver -> go EMPTY.
  - otherwise hold.
- FULL: deliver -> main <= skid, go BUSY. ex_ready_o is 0, so there is no accept.
- ex_ready_o is a flop: next value = (next state != FULL). It has no combinational dependence on mem_ready_i or ex_valid_i.
- Ordering is strictly FIFO. No entry is ever dropped or duplicated except by flush/reset.
- Latency: accepted at edge N -> visible on mem_* at N+1 (EMPTY or BUSY-with-deliver case). Throughput: 1 result/cycle while mem_ready_i=1.
- Values held while mem_valid_o=1 & mem_ready_i=0: mem_wdata_o, mem_waddr_o, mem_we_o stay stable.
- mem_we_o = main.we & mem_valid_o. The other output fields are don't-care while invalid but are zero after reset/flush.
- flush_i=1 at an edge:
  - Overrides everything: state -> EMPTY, count_o -> 0, main and skid fields cleared to 0, ex_ready_o -> 1.
  - An accept or deliver coinciding with flush is discarded: no entry is loaded.
  - The MEM side may still sample the head that cycle; the block treats it as flushed.
- Reset (rst==0 at edge): same as flush, except ex_ready_o -> 0.
  - Reset values: mem_valid_o=0, mem_wdata_o=0, mem_waddr_o=0, mem_we_o=0, count_o=0, ex_ready_o=0.
  - First edge with rst==1 sets ex_ready_o=1.
  - Reset mid-operation discards all entries.
- Reset has priority over flush_i.
- count_o: 0/1/2 for EMPTY/BUSY/FULL, registered.

Test Plan:
1. Reset with rst=0 for 2 cycles, then release -> all outputs 0 during reset; ex_ready_o=1 one cycle after release; mem_valid_o=0.
2. Single transfer {0x0000_00FF, 5'd3, we=1}, mem_ready_i=1 -> next cycle mem_valid_o=1, mem_wdata_o=0xFF, mem_waddr_o=3, mem_we_o=1; following cycle mem_valid_o=0, count_o=0.
3. Stream 4 back-to-back results (data 1,2,3,4) with mem_ready_i=1 -> MEM receives 1,2,3,4 on consecutive cycles; ex_ready_o stays 1; count_o stays 1 throughout.
4. Backpressure: mem_ready_i=0, send data 0xA then 0xB -> count_o=2, ex_ready_o=0, head stays 0xA. Raise mem_ready_i -> 0xA then 0xB delivered in order; ex_ready_o returns to 1 after the first deliver.
5. Flush while FULL (0xA, 0xB) with ex_valid_i=1 (0xC) in the same cycle -> next cycle count_o=0, mem_valid_o=0, ex_ready_o=1; 0xC is never delivered.
6. Reset mid-stream while BUSY with we=1 -> mem_we_o=0, mem_valid_o=0 and ex_ready_o=0 after the reset edge; no stale entry appears after release.
